// File: rtl/stoch_win_dec_pkg.sv
// Shared types and sizing helpers for the windowed stochastic decoder.
// Imported by the decoder top and its window counter.
package stoch_win_dec_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } state_t;

   localparam int unsigned N_DEF = 10;

   function automatic int unsigned win_max(input int unsigned n);
      return (32'd1 << n) - 32'd1;
   endfunction

endpackage

// File: rtl/stoch_win_dec_cnt.sv
// Window bit counter: counts accepted bits, flags the last bit of a window.
// Wraps to zero on the last accepted bit so windows run back to back.
module stoch_win_cnt
   import stoch_win_dec_pkg::*;
#(
   parameter int unsigned N   = N_DEF,
   parameter int unsigned WIN = win_max(N)
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_last
);

   localparam logic [N-1:0] LAST = N'(WIN - 1);

   logic [N-1:0] r_cnt;

   assign o_last = (r_cnt == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr || (i_inc && o_last)) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + N'(1);
      end
   end

endmodule

// File: rtl/stoch_win_dec.sv
// Windowed stochastic-to-binary decoder: counts ones over WIN accepted bits
// and presents each window's count through a one-entry valid/ready register.
module stoch_win_dec
   import stoch_win_dec_pkg::*;
#(
   parameter int unsigned N   = N_DEF,
   parameter int unsigned WIN = win_max(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic         in_valid,
   input  logic         Y,
   output logic [N-1:0] dout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic         ovf
);

   state_t       r_state;
   state_t       w_state_nx;
   logic [N-1:0] r_acc;
   logic [N-1:0] r_dout;
   logic         r_valid;
   logic         r_ovf;
   logic [N-1:0] w_sum;
   logic         w_take;
   logic         w_last;
   logic         w_done;
   logic         w_wclr;

   assign busy      = (r_state == ST_ACC);
   assign dout      = r_dout;
   assign out_valid = r_valid;
   assign ovf       = r_ovf;

   // Bits are only taken while enabled in ACC; dropping en discards the window.
   assign w_take = busy & en & in_valid;
   assign w_done = w_take & w_last;
   assign w_wclr = clr | ~(busy & en);
   assign w_sum  = r_acc + {{(N-1){1'b0}}, Y};

   stoch_win_cnt #(
      .N   (N),
      .WIN (WIN)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_wclr),
      .i_inc  (w_take),
      .o_last (w_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      if (clr) begin
         w_state_nx = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE: if (en)  w_state_nx = ST_ACC;
            ST_ACC:  if (!en) w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc <= '0;
      end else if (w_wclr) begin
         r_acc <= '0;
      end else if (w_take) begin
         r_acc <= w_last ? '0 : w_sum;
      end
   end

   // A completion replaces the held result; losing an unread one is sticky.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dout  <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (clr) begin
         r_dout  <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_done) begin
         r_dout  <= w_sum;
         r_valid <= 1'b1;
         if (r_valid && !out_ready) begin
            r_ovf <= 1'b1;
         end
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule
